// File: rtl/alu_issue_ctrl.sv
// Sequences one instruction at a time through an external registered ALU and owns the 8x16 register file.
// Fetch is stalled (instr_ready low) from acceptance until writeback; no forwarding is needed as a result.
module alu_issue_ctrl #(
  parameter int ALU_LATENCY = 1,
  parameter int R0_ZERO     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  alu_mode,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_result,
  output logic        wb_valid,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        flag_zero,
  output logic        flag_neg,
  output logic        busy,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [2:0] LP_LAT = 3'(ALU_LATENCY);

  state_t      r_state;
  logic [15:0] r_instr;
  logic [2:0]  r_cnt;
  logic [15:0] r_regs [8];

  logic [2:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic        w_imm_en;
  logic [2:0]  w_imm3;
  logic [15:0] w_rs1_val;
  logic [15:0] w_rs2_val;

  assign w_op     = r_instr[15:13];
  assign w_rd     = r_instr[12:10];
  assign w_rs1    = r_instr[9:7];
  assign w_rs2    = r_instr[6:4];
  assign w_imm_en = r_instr[3];
  assign w_imm3   = r_instr[2:0];

  // r0 is forced to read zero so its stored contents never matter
  assign w_rs1_val = (R0_ZERO != 0 && w_rs1 == 3'd0) ? 16'h0000 : r_regs[w_rs1];
  assign w_rs2_val = (R0_ZERO != 0 && w_rs2 == 3'd0) ? 16'h0000 : r_regs[w_rs2];
  assign dbg_data  = (R0_ZERO != 0 && dbg_addr == 3'd0) ? 16'h0000 : r_regs[dbg_addr];

  assign instr_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_instr   <= 16'h0000;
      r_cnt     <= 3'd0;
      alu_mode  <= 3'd0;
      alu_in1   <= 16'h0000;
      alu_in2   <= 16'h0000;
      wb_valid  <= 1'b0;
      wb_addr   <= 3'd0;
      wb_data   <= 16'h0000;
      flag_zero <= 1'b1;
      flag_neg  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 16'h0000;
      end
    end else begin
      wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          alu_mode <= w_op;
          alu_in1  <= w_rs1_val;
          alu_in2  <= w_imm_en ? {13'd0, w_imm3} : w_rs2_val;
          r_cnt    <= LP_LAT;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 3'd1) begin
            if (!(R0_ZERO != 0 && w_rd == 3'd0)) begin
              r_regs[w_rd] <= alu_result;
            end
            flag_zero <= (alu_result == 16'h0000);
            flag_neg  <= alu_result[15];
            wb_valid  <= 1'b1;
            wb_addr   <= w_rd;
            wb_data   <= alu_result;
            r_cnt     <= 3'd0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU with configurable pipeline depth plus a register-file/flag model.
module tb_alu_issue_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  alu_mode;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [15:0] alu_result;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flag_zero;
  logic        flag_neg;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_regs [8];
  logic        m_z;
  logic        m_n;
  logic [15:0] alu_pipe [8];

  alu_issue_ctrl #(.ALU_LATENCY(LAT), .R0_ZERO(1)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_mode(alu_mode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_zero(flag_zero), .flag_neg(flag_neg), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a >> b[3:0];
      3'd3:    return a << b[3:0];
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return ~a;
      default: return a ^ b;
    endcase
  endfunction

  // ALU result appears LAT edges after the operands are registered
  always @(posedge clk) begin
    alu_pipe[0] <= alu_f(alu_mode, alu_in1, alu_in2);
    for (int i = 1; i < 8; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = (LAT == 1) ? alu_f(alu_mode, alu_in1, alu_in2) : alu_pipe[LAT-2];

  function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2,
                                     input int ie, input int imm);
    logic [15:0] w;
    w = {op[2:0], rd[2:0], rs1[2:0], rs2[2:0], ie[0], imm[2:0]};
    return w;
  endfunction

  function automatic logic [15:0] rdm(input logic [2:0] a);
    return (a == 3'd0) ? 16'h0000 : m_regs[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [15:0] ins, input int gap);
    logic [2:0]  op, rd;
    logic [15:0] a, b, res;
    op  = ins[15:13];
    rd  = ins[12:10];
    a   = rdm(ins[9:7]);
    b   = ins[3] ? {13'd0, ins[2:0]} : rdm(ins[6:4]);
    res = alu_f(op, a, b);
    for (int g = 0; g < gap; g++) begin
      instr_valid = 1'b0;
      tick();
    end
    instr       = ins;
    instr_valid = 1'b1;
    dbg_addr    = rd;
    chk("rdy_idle", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    chk("busy", busy, 1);
    chk("rdy_busy", instr_ready, 0);
    chk("wb_pulse_end", wb_valid, 0);
    tick();
    chk("alu_mode", alu_mode, op);
    chk("alu_in1", alu_in1, a);
    chk("alu_in2", alu_in2, b);
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      chk("wb_early", wb_valid, 0);
    end
    tick();
    if (rd != 3'd0) m_regs[rd] = res;
    m_z = (res == 16'h0000);
    m_n = res[15];
    chk("wb_valid", wb_valid, 1);
    chk("wb_addr", wb_addr, rd);
    chk("wb_data", wb_data, res);
    chk("flag_zero", flag_zero, m_z);
    chk("flag_neg", flag_neg, m_n);
    chk("dbg_rd", dbg_data, rdm(rd));
    chk("rdy_after", instr_ready, 1);
  endtask

  initial begin
    int last, run, n_acc, n_wb;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_addr    = 3'd0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_z = 1'b1;
    m_n = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wb", wb_valid, 0);
    chk("rst_fz", flag_zero, 1);
    chk("rst_fn", flag_neg, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_in2", alu_in2, 0);

    do_instr(mk(0, 1, 0, 0, 1, 5), 1);
    do_instr(mk(1, 2, 1, 1, 0, 0), 0);
    do_instr(mk(1, 3, 0, 0, 1, 1), 0);
    chk("neg_r3", dbg_data, 16'hFFFF);
    do_instr(mk(0, 0, 0, 0, 1, 7), 2);
    chk("r0_zero", dbg_data, 0);

    for (int n = 0; n < 40; n++) begin
      do_instr(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7)),
               $urandom_range(0, 2));
    end

    // Reset while the instruction is waiting on the ALU
    instr       = mk(0, 4, 0, 0, 1, 3);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_z = 1'b1;
    m_n = 1'b0;
    chk("rw_wb", wb_valid, 0);
    chk("rw_ready", instr_ready, 1);
    chk("rw_fz", flag_zero, 1);
    chk("rw_mode", alu_mode, 0);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1;
      chk("rw_reg", dbg_data, 0);
    end
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk("rw_no_wb", wb_valid, 0);
    end

    // Continuous instr_valid: check spacing and one writeback per accept
    instr       = mk(0, 5, 0, 0, 1, 2);
    instr_valid = 1'b1;
    last  = -1;
    run   = 0;
    n_acc = 0;
    n_wb  = 0;
    for (int c = 0; c < 30; c++) begin
      if (instr_ready) begin
        if (last >= 0) chk("acc_gap", c - last, LAT + 2);
        last = c;
        n_acc++;
      end
      tick();
      if (wb_valid) n_wb++;
      if (!instr_ready) run++;
      else begin
        if (run > 0) chk("rdy_low", run, LAT + 1);
        run = 0;
      end
    end
    instr_valid = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      if (wb_valid) n_wb++;
    end
    chk("acc_count", n_acc, 6);
    chk("wb_count", n_wb, n_acc);
    dbg_addr = 3'd5;
    #1;
    chk("tp_r5", dbg_data, 16'h0002);
    chk("tp_fz", flag_zero, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
